// File: rtl/signal_conflict_monitor_pkg.sv
// Shared traffic definitions: lamp codes, fault causes and monitor states.
// The controller uses the same constants, so both sides always agree on encodings.
package signal_conflict_monitor_pkg;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_ENC      = 2'b01,
        FC_CONFLICT = 2'b10,
        FC_SKIP_Y   = 2'b11
    } fault_code_e;

    typedef enum logic {
        ST_MONITOR     = 1'b0,
        ST_FAULT_FLASH = 1'b1
    } state_e;

    function automatic logic lamp_legal(input logic [2:0] code);
        return (code == LAMP_R) || (code == LAMP_Y) || (code == LAMP_G);
    endfunction

    function automatic logic lamp_lit(input logic [2:0] code);
        return (code == LAMP_Y) || (code == LAMP_G);
    endfunction

endpackage

// File: rtl/signal_conflict_monitor_flash_timer.sv
// Half-period flash timer: counts HALF_CYC cycles per phase while enabled.
// Disabled means counter and phase sit at zero, so each fault starts on the red phase.
module flash_timer #(
    parameter int HALF_CYC = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick,
    output logic phase
);

    localparam int W = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam logic [W-1:0] TERM = W'(HALF_CYC - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        tick    = enable && (cnt_q == TERM);
        if (!enable) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/signal_conflict_monitor.sv
// Conflict monitor between a 4-way signal controller and the lamp drivers.
// Samples the lamp codes, trips on illegal/conflicting/skipped-yellow patterns, then flashes red.
module signal_conflict_monitor
    import signal_conflict_monitor_pkg::*;
#(
    parameter int CLK_FREQ   = 100,
    parameter int FILTER_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] north_in,
    input  logic [2:0] south_in,
    input  logic [2:0] east_in,
    input  logic [2:0] west_in,
    input  logic       fault_clr,
    output logic [2:0] north_lamp,
    output logic [2:0] south_lamp,
    output logic [2:0] east_lamp,
    output logic [2:0] west_lamp,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int HALF_CYC = (CLK_FREQ / 2 > 0) ? CLK_FREQ / 2 : 1;
    localparam int CNT_W    = (FILTER_CYC > 0) ? $clog2(FILTER_CYC + 1) : 1;

    // index 0..3 = north, south, east, west
    logic [3:0][2:0] s_q, s_d, prev_q, lamp_q, lamp_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    fault_code_e     code_q, code_d;
    state_e          state_q, state_d;

    logic [2:0] lit_cnt;
    logic       enc_flag, conf_flag, skip_flag, filt_trip, trip, all_red, clr_ok;
    logic       flash_tick, flash_phase, next_phase;

    assign s_d = {west_in, east_in, south_in, north_in};

    always_comb begin
        enc_flag  = 1'b0;
        skip_flag = 1'b0;
        lit_cnt   = 3'd0;
        all_red   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!lamp_legal(s_q[i])) enc_flag = 1'b1;
            if (lamp_lit(s_q[i]))    lit_cnt  = lit_cnt + 3'd1;
            if (s_q[i] == LAMP_R && prev_q[i] == LAMP_G) skip_flag = 1'b1;
            if (s_q[i] != LAMP_R)    all_red  = 1'b0;
        end
        conf_flag = (lit_cnt > 3'd1);
        // Static faults must persist; a skipped yellow is a single-event fault.
        filt_trip = (enc_flag || conf_flag) && ((int'(pcnt_q) + 1) >= FILTER_CYC);
        trip      = (state_q == ST_MONITOR) && (filt_trip || skip_flag);
        clr_ok    = fault_clr && all_red;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MONITOR:     if (trip)   state_d = ST_FAULT_FLASH;
            ST_FAULT_FLASH: if (clr_ok) state_d = ST_MONITOR;
            default:                    state_d = ST_MONITOR;
        endcase
    end

    always_comb begin
        pcnt_d = '0;
        code_d = code_q;
        if (state_q == ST_MONITOR) begin
            code_d = FC_NONE;
            if (trip) begin
                if (enc_flag)       code_d = FC_ENC;
                else if (conf_flag) code_d = FC_CONFLICT;
                else                code_d = FC_SKIP_Y;
            end else if (enc_flag || conf_flag) begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end else if (clr_ok) begin
            code_d = FC_NONE;
        end
        // Lamps register the value the outputs must show next cycle.
        next_phase = (state_q == ST_FAULT_FLASH) ? (flash_phase ^ flash_tick) : 1'b0;
        lamp_d     = s_d;
        if (state_d == ST_FAULT_FLASH)
            lamp_d = next_phase ? {4{LAMP_OFF}} : {4{LAMP_R}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_MONITOR;
            s_q     <= {4{LAMP_R}};
            prev_q  <= {4{LAMP_R}};
            lamp_q  <= {4{LAMP_R}};
            pcnt_q  <= '0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            prev_q  <= s_q;
            lamp_q  <= lamp_d;
            pcnt_q  <= pcnt_d;
            code_q  <= code_d;
        end
    end

    flash_timer #(.HALF_CYC(HALF_CYC)) u_flash_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == ST_FAULT_FLASH),
        .tick   (flash_tick),
        .phase  (flash_phase)
    );

    assign north_lamp = lamp_q[0];
    assign south_lamp = lamp_q[1];
    assign east_lamp  = lamp_q[2];
    assign west_lamp  = lamp_q[3];
    assign fault      = (state_q == ST_FAULT_FLASH);
    assign fault_code = code_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed bench for signal_conflict_monitor at default parameters (50-cycle flash halves).
module tb_signal_conflict_monitor;

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] north_in, south_in, east_in, west_in;
    logic       fault_clr;
    logic [2:0] north_lamp, south_lamp, east_lamp, west_lamp;
    logic       fault;
    logic [1:0] fault_code;

    int passed = 0;
    int total  = 0;

    signal_conflict_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .north_in   (north_in),
        .south_in   (south_in),
        .east_in    (east_in),
        .west_in    (west_in),
        .fault_clr  (fault_clr),
        .north_lamp (north_lamp),
        .south_lamp (south_lamp),
        .east_lamp  (east_lamp),
        .west_lamp  (west_lamp),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] lamps();
        return {20'd0, north_lamp, south_lamp, east_lamp, west_lamp};
    endfunction

    initial begin
        reset = 1'b1; fault_clr = 1'b0;
        north_in = R; south_in = R; east_in = R; west_in = R;
        tick(); tick();
        chk("rst_lamps", lamps(), {20'd0, R, R, R, R});
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        reset = 1'b0;

        // normal sequence, one cycle latency
        north_in = G;
        #1 chk("latency_pre", north_lamp, R);
        tick(); chk("n_green", north_lamp, G);
        north_in = Y; tick(); chk("n_yellow", north_lamp, Y);
        north_in = R; tick(); chk("n_red", north_lamp, R);
        east_in = G;  tick(); chk("e_green", east_lamp, G);
        east_in = Y;  tick(); chk("e_yellow", east_lamp, Y);
        east_in = R;  tick(); chk("e_red", east_lamp, R);
        chk("normal_fault", fault, 0);

        // one-cycle conflict glitch must be filtered
        north_in = Y; east_in = Y; tick();
        north_in = R; east_in = R; tick(); tick();
        chk("glitch_fault", fault, 0);
        chk("glitch_code", fault_code, 0);

        // two-cycle conflict trips
        north_in = G; east_in = G; tick(); tick();
        chk("conf_notyet", fault, 0);
        north_in = R; east_in = R; tick();
        chk("conf_fault", fault, 1);
        chk("conf_code", fault_code, 2);
        chk("conf_lamps_r", lamps(), {20'd0, R, R, R, R});
        repeat (49) tick();
        chk("flash_r_end", lamps(), {20'd0, R, R, R, R});
        tick();
        chk("flash_off_start", lamps(), {20'd0, O, O, O, O});
        repeat (49) tick();
        chk("flash_off_end", lamps(), {20'd0, O, O, O, O});
        tick();
        chk("flash_r_again", lamps(), {20'd0, R, R, R, R});

        // clear refused while south is yellow, accepted once all red
        south_in = Y; tick();
        fault_clr = 1'b1; tick(); tick();
        chk("clr_blocked", fault, 1);
        chk("clr_blocked_code", fault_code, 2);
        south_in = R; tick();
        chk("clr_wait", fault, 1);
        tick();
        chk("clr_fault", fault, 0);
        chk("clr_code", fault_code, 0);
        chk("clr_lamps", lamps(), {20'd0, R, R, R, R});
        fault_clr = 1'b0;

        // skipped yellow trips without filtering
        north_in = G; tick(); chk("sy_green", north_lamp, G);
        north_in = R; tick();
        chk("sy_notyet", fault, 0);
        chk("sy_red_pass", north_lamp, R);
        tick();
        chk("sy_fault", fault, 1);
        chk("sy_code", fault_code, 3);
        fault_clr = 1'b1; tick();
        chk("sy_clr", fault, 0);
        chk("sy_clr_code", fault_code, 0);
        fault_clr = 1'b0;

        // fault_clr in MONITOR has no effect
        fault_clr = 1'b1; north_in = G; tick();
        chk("clr_in_mon", north_lamp, G);
        fault_clr = 1'b0; north_in = Y; tick(); north_in = R; tick();

        // coincident encoding + conflict: encoding wins
        west_in = 3'b111; north_in = G; east_in = Y; tick();
        chk("coinc_pass_w", west_lamp, 3'b111);
        tick();
        north_in = R; east_in = R; west_in = R; tick();
        chk("coinc_fault", fault, 1);
        chk("coinc_code", fault_code, 1);

        // reset mid-flash acts immediately
        repeat (55) tick();
        chk("mid_off", lamps(), {20'd0, O, O, O, O});
        reset = 1'b1;
        #1;
        chk("async_lamps", lamps(), {20'd0, R, R, R, R});
        chk("async_fault", fault, 0);
        chk("async_code", fault_code, 0);
        tick();
        reset = 1'b0;
        north_in = G; tick();
        chk("post_rst_pass", north_lamp, G);
        chk("post_rst_fault", fault, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/signal_conflict_monitor.md
SIGNAL_CONFLICT_MONITOR -- requirements
Module: signal_conflict_monitor

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100, meaning clock cycles per second.
REQ-002 SHALL have parameter FILTER_CYC, default 2, meaning consecutive cycles a static fault must persist before tripping.
REQ-003 SHALL have input clk, 1 bit: system clock, all state on rising edge.
REQ-004 SHALL have input reset, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have inputs north_in, south_in, east_in, west_in, each 3 bits: lamp codes from the 4-way controller (R=100, Y=010, G=001).
REQ-006 SHALL have input fault_clr, 1 bit: operator request to leave the fault state.
REQ-007 SHALL have outputs north_lamp, south_lamp, east_lamp, west_lamp, each 3 bits: registered lamp drive.
REQ-008 SHALL have output fault, 1 bit: high while in FAULT_FLASH.
REQ-009 SHALL have output fault_code, 2 bits: 00 none, 01 illegal encoding, 10 conflict, 11 skipped yellow; latched cause.

Function
REQ-010 SHALL register all four input codes every cycle into sample registers (stage S).
REQ-011 SHALL evaluate faults on stage S and drive lamp outputs from stage S, giving exactly 1 cycle input-to-lamp latency in MONITOR.
REQ-012 SHALL flag illegal encoding when any sampled code is not R, Y or G.
REQ-013 SHALL flag conflict when more than one sampled approach is non-red (Y or G).
REQ-014 SHALL flag skipped yellow when any approach's sample is R and its previous-cycle sample was G; this flag trips immediately, no filtering.
REQ-015 SHALL keep a persistence counter, incremented while encoding or conflict flag is active, cleared when both are inactive; trip when it reaches FILTER_CYC.
REQ-016 SHALL implement states MONITOR and FAULT_FLASH; MONITOR -> FAULT_FLASH on trip; FAULT_FLASH -> MONITOR only when fault_clr=1 and all four sampled codes are R in the same cycle.
REQ-017 SHALL, on trip, latch fault_code with priority encoding(01) > conflict(10) > skipped yellow(11) when several flags coincide.
REQ-018 SHALL hold fault_code and ignore new flags while in FAULT_FLASH.
REQ-019 SHALL, in FAULT_FLASH, drive all four lamps R for CLK_FREQ/2 cycles then 000 for CLK_FREQ/2 cycles, repeating; the flash timer starts at the R phase on entry.
REQ-020 SHALL, on the cycle after return to MONITOR, resume passthrough, clear fault and fault_code to 00, and clear the persistence counter.
REQ-021 SHALL ignore fault_clr in MONITOR.
REQ-022 SHALL size the flash timer to hold CLK_FREQ/2-1 without overflow and wrap it to 0 at the terminal count.

Reset
REQ-023 SHALL on reset set state MONITOR, all sample and previous-sample registers to R, all lamp outputs to 100, fault 0, fault_code 00, persistence and flash counters 0.
REQ-024 SHALL, when reset asserts mid-flash, force the reset values immediately regardless of flash phase.

Structure
REQ-025 SHALL take lamp code constants (R, Y, G) and fault_code values from a shared traffic package also used by the controller.
REQ-026 SHALL place the flash timer in one sub-module, flash_timer (enable, tick output, phase output).

Verification
REQ-027 Normal cycle: controller-legal sequence N G->Y->R, E G->Y->R -> lamps follow inputs 1 cycle late, fault stays 0.
REQ-028 Conflict: north_in=001 and east_in=001 for 2 cycles -> fault=1, fault_code=10 on next edge, lamps 100 for 50 cycles then 000 for 50 cycles.
REQ-029 Glitch: conflict for 1 cycle only -> no trip, fault=0.
REQ-030 Skipped yellow: north_in 001 -> 100 directly -> fault=1, fault_code=11 one cycle after the R sample.
REQ-031 Coincident: west_in=111 while north_in=001, east_in=010 for 2 cycles -> fault_code=01.
REQ-032 Clear/reset: fault_clr=1 with south_in=010 -> stays in fault; fault_clr=1 with all R -> MONITOR, fault_code=00; reset asserted mid-flash -> lamps 100, fault 0 immediately.
